// File: rtl/median_filter_3x3_calc_pkg.sv
// Shared constants and the {min, med, max} triple used by the 3x3 median pipeline.
package median_filter_3x3_calc_pkg;

  localparam int DATA_W       = 8;
  localparam int MEDF_LATENCY = 3;

  typedef struct packed {
    logic [DATA_W-1:0] min_v;
    logic [DATA_W-1:0] med_v;
    logic [DATA_W-1:0] max_v;
  } sort3_t;

endpackage

// File: rtl/median_filter_3x3_calc_sort3.sv
// Combinational unsigned 3-input sorter producing {min, med, max}.
module median_filter_3x3_calc_sort3
  import median_filter_3x3_calc_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output sort3_t            o_sorted
);

  logic [DATA_W-1:0] w_lo_ab;
  logic [DATA_W-1:0] w_hi_ab;
  logic [DATA_W-1:0] w_lo_hc;

  assign w_lo_ab = (i_a < i_b) ? i_a : i_b;
  assign w_hi_ab = (i_a < i_b) ? i_b : i_a;
  assign w_lo_hc = (w_hi_ab < i_c) ? w_hi_ab : i_c;

  // The middle value is the larger of the pair minimum and min(pair max, c).
  assign o_sorted.min_v = (w_lo_ab < i_c) ? w_lo_ab : i_c;
  assign o_sorted.max_v = (w_hi_ab > i_c) ? w_hi_ab : i_c;
  assign o_sorted.med_v = (w_lo_ab > w_lo_hc) ? w_lo_ab : w_lo_hc;

endmodule

// File: rtl/median_filter_3x3_calc.sv
// Three-stage free-running median of a 3x3 window: row sort, column reduce, final median.
// done_i is a valid-only strobe (no ready); done_o is done_i delayed MEDF_LATENCY edges.
module median_filter_3x3_calc
  import median_filter_3x3_calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] S1,
  input  logic [DATA_W-1:0] S2,
  input  logic [DATA_W-1:0] S3,
  input  logic [DATA_W-1:0] S4,
  input  logic [DATA_W-1:0] S5,
  input  logic [DATA_W-1:0] S6,
  input  logic [DATA_W-1:0] S7,
  input  logic [DATA_W-1:0] S8,
  input  logic [DATA_W-1:0] S9,
  output logic [DATA_W-1:0] median_o,
  output logic              done_o
);

  sort3_t w_row [3];
  sort3_t r_row [3];
  sort3_t w_mins_s;
  sort3_t w_meds_s;
  sort3_t w_maxs_s;
  sort3_t w_fin_s;

  logic [DATA_W-1:0]       r_max_of_mins;
  logic [DATA_W-1:0]       r_med_of_meds;
  logic [DATA_W-1:0]       r_min_of_maxs;
  logic [DATA_W-1:0]       r_median;
  logic [MEDF_LATENCY-1:0] r_done;

  median_filter_3x3_calc_sort3 u_row0 (.i_a(S1), .i_b(S2), .i_c(S3), .o_sorted(w_row[0]));
  median_filter_3x3_calc_sort3 u_row1 (.i_a(S4), .i_b(S5), .i_c(S6), .o_sorted(w_row[1]));
  median_filter_3x3_calc_sort3 u_row2 (.i_a(S7), .i_b(S8), .i_c(S9), .o_sorted(w_row[2]));

  median_filter_3x3_calc_sort3 u_mins (
    .i_a(r_row[0].min_v), .i_b(r_row[1].min_v), .i_c(r_row[2].min_v), .o_sorted(w_mins_s));
  median_filter_3x3_calc_sort3 u_meds (
    .i_a(r_row[0].med_v), .i_b(r_row[1].med_v), .i_c(r_row[2].med_v), .o_sorted(w_meds_s));
  median_filter_3x3_calc_sort3 u_maxs (
    .i_a(r_row[0].max_v), .i_b(r_row[1].max_v), .i_c(r_row[2].max_v), .o_sorted(w_maxs_s));

  median_filter_3x3_calc_sort3 u_fin (
    .i_a(r_max_of_mins), .i_b(r_med_of_meds), .i_c(r_min_of_maxs), .o_sorted(w_fin_s));

  // Each reduction sorter contributes one field; the rest is intentionally dropped.
  logic w_unused;
  assign w_unused = &{1'b0, w_mins_s.min_v, w_mins_s.med_v, w_meds_s.min_v, w_meds_s.max_v,
                      w_maxs_s.med_v, w_maxs_s.max_v, w_fin_s.min_v, w_fin_s.max_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) r_row[k] <= '0;
      r_max_of_mins <= '0;
      r_med_of_meds <= '0;
      r_min_of_maxs <= '0;
      r_median      <= '0;
      r_done        <= '0;
    end else begin
      for (int k = 0; k < 3; k++) r_row[k] <= w_row[k];
      r_max_of_mins <= w_mins_s.max_v;
      r_med_of_meds <= w_meds_s.med_v;
      r_min_of_maxs <= w_maxs_s.min_v;
      r_median      <= w_fin_s.med_v;
      r_done        <= {r_done[MEDF_LATENCY-2:0], done_i};
    end
  end

  assign median_o = r_median;
  assign done_o   = r_done[MEDF_LATENCY-1];

endmodule

// File: tb/tb_median_filter_3x3_calc.sv
// Directed and random windows for the 3x3 median pipeline, scoreboarded by value and arrival edge.
module tb_median_filter_3x3_calc;
  import median_filter_3x3_calc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              done_i = 1'b0;
  logic [DATA_W-1:0] s [9];
  logic [DATA_W-1:0] median_o;
  logic              done_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];

  median_filter_3x3_calc dut (
    .clk(clk), .rst(rst), .done_i(done_i),
    .S1(s[0]), .S2(s[1]), .S3(s[2]), .S4(s[3]), .S5(s[4]),
    .S6(s[5]), .S7(s[6]), .S8(s[7]), .S9(s[8]),
    .median_o(median_o), .done_o(done_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_median(input logic [9*DATA_W-1:0] w);
    logic [DATA_W-1:0] v [9];
    logic [DATA_W-1:0] t;
    for (int k = 0; k < 9; k++) v[k] = w[(8-k)*DATA_W +: DATA_W];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  // driver tasks
  task automatic drive(input logic d, input logic [9*DATA_W-1:0] w, input logic [DATA_W-1:0] exp_m);
    @(negedge clk);
    done_i = d;
    for (int k = 0; k < 9; k++) s[k] = w[(8-k)*DATA_W +: DATA_W];
    if (d) begin
      exp_q.push_back(exp_m);
      exp_cyc_q.push_back(cyc + MEDF_LATENCY);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  // scoreboard: every done_o must match the oldest expected window on its due edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {31'd0, done_o}, 32'd0);
        end else begin
          check("median", {24'd0, median_o}, {24'd0, exp_q.pop_front()});
          check("latency", cyc, exp_cyc_q.pop_front());
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        check("missing_done", {31'd0, done_o}, 32'd1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    logic [9*DATA_W-1:0] w;
    for (int k = 0; k < 9; k++) s[k] = '0;

    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_median", {24'd0, median_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("idle_median", {24'd0, median_o}, 32'd0);
      check("idle_done", {31'd0, done_o}, 32'd0);
    end

    // 2: single window, median 0
    drive(1'b1, {8'd0, 8'd0, 8'd0, 8'd12, 8'd24, 8'd0, 8'd61, 8'd72, 8'd0}, 8'd0);
    idle(5);

    // 3: mixed window, median 50
    drive(1'b1, {8'd20, 8'd90, 8'd60, 8'd30, 8'd10, 8'd70, 8'd50, 8'd40, 8'd80}, 8'd50);
    idle(2);

    // 4: back-to-back windows
    drive(1'b1, {8'd25, 8'd35, 8'd45, 8'd55, 8'd65, 8'd75, 8'd85, 8'd95, 8'd105}, 8'd65);
    drive(1'b1, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd5);
    drive(1'b1, {9{8'd255}}, 8'd255);
    idle(4);

    // 5: duplicates and extremes
    drive(1'b1, {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255}, 8'd255);
    drive(1'b1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd1}, 8'd1);
    idle(4);

    // 6: reset with two windows in flight
    drive(1'b1, {8'd20, 8'd90, 8'd60, 8'd30, 8'd10, 8'd70, 8'd50, 8'd40, 8'd80}, 8'd50);
    drive(1'b1, {9{8'd200}}, 8'd200);
    @(posedge clk);
    #3;
    rst    = 1'b1;
    done_i = 1'b0;
    #1;
    check("async_rst_done", {31'd0, done_o}, 32'd0);
    check("async_rst_median", {24'd0, median_o}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_rst_done", {31'd0, done_o}, 32'd0);
    end

    // random windows with random gaps against the sort-of-9 reference
    repeat (10000) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      w = {$urandom(), $urandom(), $urandom()};
      drive(1'b1, w, ref_median(w));
    end
    idle(6);

    check("drain_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
